cam_stream_arbiter: RTL
=======================

# cam_stream_arbiter

Frame-aligned source arbiter and flow controller between the two pixel producers (the OV7670 camera handler and the debug pattern generator) and the 17-bit camera-input FIFO that feeds the PSRAM video controller. It holds the stream off until PSRAM calibration completes. It switches sources only on frame boundaries. It never lets a partial frame reach the FIFO without marking the fault.

## Interface

Parameters:
- FRAME_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- DROP_CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- PixelClk  in  1  pixel clock; all logic runs on it.
- nRST  in  1  asynchronous, active-low reset.
- init_done  in  1  PSRAM calibration done, from the clk_2 domain; synchronised internally.
- src_sel  in  1  requested source: 0 = camera, 1 = pattern; level, may change at any time.
- cam_data  in  17  camera word; bit 16 = start-of-frame (SOF), bits 15:0 = RGB565.
- cam_valid  in  1  camera word valid; the camera cannot be stalled.
- pat_data  in  17  pattern word, same format.
- pat_valid  in  1  pattern word valid.
- pat_ready  out  1  pattern back-pressure.
- fifo_full  in  1  FIFO Full flag.
- fifo_data  out  17  FIFO write data.
- fifo_wr_en  out  1  FIFO write enable.
- active_src  out  1  source currently owning the FIFO.
- stream_on  out  1  high while in STREAM.
- overflow_n  out  1  sticky fault flag, active low (drives the debug LED).
- drop_cnt  out  DROP_CNT_W  saturating count of aborted frames.

## Operation

State machine (registered):
- **WAIT_CALIB**: entered from reset.
  - pat_ready = 0; no writes.
  - Moves to WAIT_SOF on the first cycle the synchronised init_done is 1.
- **WAIT_SOF**: candidate source = current src_sel, re-evaluated every cycle.
  - Words from the candidate without SOF are discarded. For the pattern source, pat_ready = 1 and the word is consumed.
  - On a candidate word with SOF=1 and fifo_full=0: active_src <= candidate, the word is written, pixel counter <= 1, state goes to STREAM.
  - SOF with fifo_full=1: the word is discarded and the state stays in WAIT_SOF.
- **STREAM**: words from active_src are forwarded.
  - pat_ready = !fifo_full when active_src = 1; otherwise 0.
  - On each write the pixel counter increments.
  - The write of word FRAME_WIDTH×FRAME_HEIGHT ends the frame and moves to WAIT_SOF.
  - Camera word with fifo_full=1: the word is lost. drop_cnt +1 (saturating), overflow_n <= 0, state goes to DROP.
  - SOF word arriving before the count completes (short frame): drop_cnt +1, overflow_n <= 0. The SOF is written as a new frame start and the counter <= 1; the state stays in STREAM.
- **DROP**: all words are discarded; pat_ready = 0.
  - Moves to WAIT_SOF when fifo_full=0. The next SOF restarts cleanly.
- The non-active source is ignored in STREAM and DROP.
- src_sel changes take effect only at the next WAIT_SOF. There is no switch mid-frame.
- A deassertion of synchronised init_done in any state returns the FSM to WAIT_CALIB. An open frame is counted as dropped.

Arithmetic:
- The pixel counter width is clog2(FRAME_WIDTH×FRAME_HEIGHT+1), i.e. 19 bits for 640×480.
- drop_cnt saturates at all-ones.
- overflow_n clears only on reset.

## Timing

- fifo_wr_en and fifo_data are combinational from the selected source's valid and data, gated by state and !fifo_full. There is zero-cycle latency from input to FIFO write, and no write is ever issued while fifo_full=1.
- pat_ready is combinational from state, active_src and fifo_full. A pattern word is transferred iff pat_valid && pat_ready.
- State, counter, active_src, drop_cnt and overflow_n update on the PixelClk edge following the event.
- init_done passes through a 2-flop synchroniser. The first write can occur no earlier than the 3rd PixelClk edge after init_done rises.
- Reset values:
  - state = WAIT_CALIB; active_src = 0; stream_on = 0; overflow_n = 1; drop_cnt = 0; pixel counter = 0.
  - fifo_wr_en = 0; pat_ready = 0; fifo_data = 0.
- Reset asserted mid-frame aborts immediately. drop_cnt is not incremented; it is cleared.

## Structure

- Shared package/defs header (`camera_control_defs.vh`) holds:
  - the state encodings (2 bits);
  - SOF_BIT = 16;
  - SRC_CAM = 0 and SRC_PAT = 1;
  - the 17-bit word width constant.
- One sub-module: `sync_2ff`, a generic 2-flop level synchroniser, used for init_done.
- Everything else is flat in cam_stream_arbiter.

## Test plan

- **Calibration gating:** init_done=0 for 100 cycles with the pattern valid → fifo_wr_en stays 0 and pat_ready stays 0. Then raise init_done → the first write is the SOF word, no earlier than edge 3.
- **Full frame, pattern source:** use a 4×2 frame with fifo_full toggling every other cycle → exactly 8 writes, SOF only on the first, no write while full, state returns to WAIT_SOF.
- **Camera overflow:** camera streaming and fifo_full=1 mid-frame for 1 cycle → that word is not written, drop_cnt=1, overflow_n=0. Writes resume at the next SOF, and remaining words of the aborted frame are discarded.
- **Source switch:** flip src_sel from 0 to 1 mid-frame → the camera frame completes, and the next written SOF comes from the pattern with active_src=1.
- **Short frame:** a camera SOF arrives after 5 of 8 words → drop_cnt +1, the SOF is written, and the counter restarts at 1.
- **Saturation and reset:** force 300 drops → drop_cnt=255. Assert nRST mid-frame → all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/cam_stream_arbiter_pkg.sv
// cam_stream_arbiter_pkg
// Shared definitions for the camera stream arbiter:
//   - arbiter FSM state encodings (2 bits)
//   - stream word layout (17 bits, bit 16 = start-of-frame)
//   - source identifiers for src_sel / active_src
package cam_stream_arbiter_pkg;

  localparam int WORD_W  = 17;
  localparam int SOF_BIT = 16;

  localparam logic SRC_CAM = 1'b0;
  localparam logic SRC_PAT = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT_CALIB = 2'd0,
    ST_WAIT_SOF   = 2'd1,
    ST_STREAM     = 2'd2,
    ST_DROP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cam_stream_arbiter_sync_2ff.sv
// sync_2ff
// Generic two-flop level synchroniser for slow, quasi-static signals
// crossing into the PixelClk domain.
// Ports:
//   PixelClk  destination clock
//   nRST      asynchronous active-low reset (output resets to 0)
//   d         asynchronous input level
//   q         synchronised level, two PixelClk edges behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cam_stream_arbiter.sv
// cam_stream_arbiter
// Frame-aligned arbiter between the camera handler and the debug pattern
// generator, feeding the 17-bit camera-input FIFO in front of the PSRAM
// video controller. The stream is held off until PSRAM calibration is
// done, sources only change on frame boundaries, and any partial frame
// that reaches the FIFO is flagged on overflow_n / drop_cnt.
// Ports:
//   PixelClk, nRST        clock, asynchronous active-low reset
//   init_done             PSRAM calibration done (other clock domain)
//   src_sel               requested source (0 camera, 1 pattern)
//   cam_data, cam_valid   camera words (cannot be stalled)
//   pat_data, pat_valid   pattern words
//   pat_ready             pattern back-pressure
//   fifo_full             FIFO full flag
//   fifo_data, fifo_wr_en FIFO write port
//   active_src            source owning the current/last frame
//   stream_on             high while a frame is being forwarded
//   overflow_n            sticky fault flag, active low
//   drop_cnt              saturating count of aborted frames
module cam_stream_arbiter
  import cam_stream_arbiter_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  PixelClk,
  input  logic                  nRST,
  input  logic                  init_done,
  input  logic                  src_sel,
  input  logic [WORD_W-1:0]     cam_data,
  input  logic                  cam_valid,
  input  logic [WORD_W-1:0]     pat_data,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic                  fifo_full,
  output logic [WORD_W-1:0]     fifo_data,
  output logic                  fifo_wr_en,
  output logic                  active_src,
  output logic                  stream_on,
  output logic                  overflow_n,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] PEN_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] ONE_PIX = CNT_W'(1);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  pix_cnt, pix_cnt_nxt;
  logic              active_src_nxt;
  logic              init_sync;
  logic              drop_inc;
  logic              fault;
  logic              wr;
  logic              cand_src;
  logic [WORD_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_sof;

  sync_2ff #(.WIDTH(1)) u_init_sync (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .d        (init_done),
    .q        (init_sync)
  );

  // While hunting for a frame start the candidate follows src_sel live;
  // once a frame is open the owner is frozen in active_src.
  assign cand_src  = (state == ST_WAIT_SOF) ? src_sel : active_src;
  assign sel_data  = (cand_src == SRC_PAT) ? pat_data  : cam_data;
  assign sel_valid = (cand_src == SRC_PAT) ? pat_valid : cam_valid;
  assign sel_sof   = sel_data[SOF_BIT];

  always_comb begin
    state_nxt      = state;
    pix_cnt_nxt    = pix_cnt;
    active_src_nxt = active_src;
    drop_inc       = 1'b0;
    fault          = 1'b0;
    wr             = 1'b0;
    pat_ready      = 1'b0;

    if (!init_sync) begin
      // Losing calibration kills any open frame; it counts as dropped.
      state_nxt   = ST_WAIT_CALIB;
      pix_cnt_nxt = '0;
      if (state == ST_STREAM) drop_inc = 1'b1;
    end else begin
      case (state)
        ST_WAIT_CALIB: begin
          state_nxt = ST_WAIT_SOF;
        end

        ST_WAIT_SOF: begin
          // Pattern words ahead of SOF are consumed and thrown away so the
          // generator never stalls waiting for a frame start.
          pat_ready = (src_sel == SRC_PAT);
          if (sel_valid && sel_sof && !fifo_full) begin
            wr             = 1'b1;
            active_src_nxt = src_sel;
            pix_cnt_nxt    = ONE_PIX;
            state_nxt      = ST_STREAM;
          end
        end

        ST_STREAM: begin
          pat_ready = (active_src == SRC_PAT) && !fifo_full;
          if (sel_valid) begin
            if (fifo_full) begin
              // The pattern simply stalls; a camera word is lost for good.
              if (active_src == SRC_CAM) begin
                drop_inc    = 1'b1;
                fault       = 1'b1;
                pix_cnt_nxt = '0;
                state_nxt   = ST_DROP;
              end
            end else begin
              wr = 1'b1;
              if (sel_sof) begin
                // Short frame: flag it, but keep the new SOF as a fresh start.
                drop_inc    = 1'b1;
                fault       = 1'b1;
                pix_cnt_nxt = ONE_PIX;
              end else if (pix_cnt == PEN_PIX) begin
                pix_cnt_nxt = '0;
                state_nxt   = ST_WAIT_SOF;
              end else begin
                pix_cnt_nxt = pix_cnt + ONE_PIX;
              end
            end
          end
        end

        ST_DROP: begin
          if (!fifo_full) state_nxt = ST_WAIT_SOF;
        end

        default: begin
          state_nxt = ST_WAIT_CALIB;
        end
      endcase
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_WAIT_CALIB;
      pix_cnt    <= '0;
      active_src <= SRC_CAM;
      overflow_n <= 1'b1;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      active_src <= active_src_nxt;
      if (fault) overflow_n <= 1'b0;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Data is zeroed when not writing so the FIFO port is quiet in reset.
  assign fifo_wr_en = wr;
  assign fifo_data  = wr ? sel_data : '0;
  assign stream_on  = (state == ST_STREAM);

endmodule
